// File: rtl/ttt_turn_scheduler_if.sv
// Signal bundle between the tic-tac-toe turn scheduler, its move sources and the board datapath.
interface ttt_turn_scheduler_if;
    logic       start;
    logic       pl_req;
    logic [3:0] pl_pos;
    logic       pc_req;
    logic [3:0] pc_pos;
    logic [8:0] board_occ;
    logic       win;
    logic       no_space;
    logic [8:0] wr_pl_en;
    logic [8:0] wr_pc_en;
    logic       clear_board;
    logic       pl_ack;
    logic       pc_ack;
    logic       pl_nack;
    logic       pc_nack;
    logic [1:0] turn;
    logic [3:0] move_count;
    logic       game_over;
    logic [1:0] result;
    logic       timeout;

    modport slave (
        input  start, pl_req, pl_pos, pc_req, pc_pos, board_occ, win, no_space,
        output wr_pl_en, wr_pc_en, clear_board, pl_ack, pc_ack, pl_nack, pc_nack,
               turn, move_count, game_over, result, timeout
    );

    modport master (
        output start, pl_req, pl_pos, pc_req, pc_pos, board_occ, win, no_space,
        input  wr_pl_en, wr_pc_en, clear_board, pl_ack, pc_ack, pl_nack, pc_nack,
               turn, move_count, game_over, result, timeout
    );
endinterface

// File: rtl/ttt_turn_scheduler.sv
// Tic-tac-toe game sequencer: turn alternation, move legality, board write enables,
// result detection and computer-move forfeit timer. All outputs are registered.
module ttt_turn_scheduler #(
    parameter logic        PC_FIRST       = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    ttt_turn_scheduler_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_PL_TURN = 3'd2,
        S_PC_TURN = 3'd3,
        S_WRITE   = 3'd4,
        S_CHECK   = 3'd5,
        S_DONE    = 3'd6
    } state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    function automatic logic pos_legal(input logic [3:0] pos, input logic [8:0] occ);
        if ((pos >= 4'd1) && (pos <= 4'd9)) begin
            return ~occ[pos - 4'd1];
        end else begin
            return 1'b0;
        end
    endfunction

    function automatic logic [8:0] pos_onehot(input logic [3:0] pos);
        return 9'd1 << (pos - 4'd1);
    endfunction

    state_e     state_q, state_d;
    logic [3:0] move_count_q, move_count_d;
    logic [1:0] result_q, result_d;
    logic [1:0] last_mover_q, last_mover_d;
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic [8:0] wr_pl_en_q, wr_pl_en_d;
    logic [8:0] wr_pc_en_q, wr_pc_en_d;
    logic       clear_board_q, clear_board_d;
    logic       pl_ack_q, pl_ack_d;
    logic       pc_ack_q, pc_ack_d;
    logic       pl_nack_q, pl_nack_d;
    logic       pc_nack_q, pc_nack_d;
    logic [1:0] turn_q, turn_d;
    logic       game_over_q, game_over_d;
    logic       timeout_q, timeout_d;

    // Next-state and registered-output decode.
    always_comb begin
        state_d       = state_q;
        move_count_d  = move_count_q;
        result_d      = result_q;
        last_mover_d  = last_mover_q;
        tmo_cnt_d     = tmo_cnt_q;
        wr_pl_en_d    = 9'd0;
        wr_pc_en_d    = 9'd0;
        clear_board_d = 1'b0;
        pl_ack_d      = 1'b0;
        pc_ack_d      = 1'b0;
        pl_nack_d     = 1'b0;
        pc_nack_d     = 1'b0;
        timeout_d     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d       = S_CLEAR;
                    clear_board_d = 1'b1;
                    move_count_d  = 4'd0;
                    result_d      = 2'b00;
                end else begin
                    state_d = state_q;
                end
            end
            S_CLEAR: begin
                tmo_cnt_d = 8'd0;
                state_d   = PC_FIRST ? S_PC_TURN : S_PL_TURN;
            end
            S_PL_TURN: begin
                pc_nack_d = bus.pc_req;
                if (bus.pl_req && pos_legal(bus.pl_pos, bus.board_occ)) begin
                    wr_pl_en_d   = pos_onehot(bus.pl_pos);
                    pl_ack_d     = 1'b1;
                    move_count_d = move_count_q + 4'd1;
                    last_mover_d = 2'b01;
                    state_d      = S_WRITE;
                end else begin
                    pl_nack_d = bus.pl_req;
                end
            end
            S_PC_TURN: begin
                pl_nack_d = bus.pl_req;
                if (bus.pc_req && pos_legal(bus.pc_pos, bus.board_occ)) begin
                    wr_pc_en_d   = pos_onehot(bus.pc_pos);
                    pc_ack_d     = 1'b1;
                    move_count_d = move_count_q + 4'd1;
                    last_mover_d = 2'b10;
                    state_d      = S_WRITE;
                end else begin
                    pc_nack_d = bus.pc_req;
                    // A computer that cannot produce a legal move in time forfeits.
                    if (tmo_cnt_q == TMO_LAST) begin
                        timeout_d = 1'b1;
                        result_d  = 2'b01;
                        state_d   = S_DONE;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 8'd1;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (bus.win) begin
                    result_d = last_mover_q;
                    state_d  = S_DONE;
                end else if (bus.no_space || (move_count_q == 4'd9)) begin
                    result_d = 2'b11;
                    state_d  = S_DONE;
                end else begin
                    tmo_cnt_d = 8'd0;
                    state_d   = (last_mover_q == 2'b01) ? S_PC_TURN : S_PL_TURN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_PL_TURN: turn_d = 2'b01;
            S_PC_TURN: turn_d = 2'b10;
            default:   turn_d = 2'b00;
        endcase
        game_over_d = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            move_count_q  <= 4'd0;
            result_q      <= 2'b00;
            last_mover_q  <= 2'b00;
            tmo_cnt_q     <= 8'd0;
            wr_pl_en_q    <= 9'd0;
            wr_pc_en_q    <= 9'd0;
            clear_board_q <= 1'b0;
            pl_ack_q      <= 1'b0;
            pc_ack_q      <= 1'b0;
            pl_nack_q     <= 1'b0;
            pc_nack_q     <= 1'b0;
            turn_q        <= 2'b00;
            game_over_q   <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            move_count_q  <= move_count_d;
            result_q      <= result_d;
            last_mover_q  <= last_mover_d;
            tmo_cnt_q     <= tmo_cnt_d;
            wr_pl_en_q    <= wr_pl_en_d;
            wr_pc_en_q    <= wr_pc_en_d;
            clear_board_q <= clear_board_d;
            pl_ack_q      <= pl_ack_d;
            pc_ack_q      <= pc_ack_d;
            pl_nack_q     <= pl_nack_d;
            pc_nack_q     <= pc_nack_d;
            turn_q        <= turn_d;
            game_over_q   <= game_over_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.wr_pl_en    = wr_pl_en_q;
    assign bus.wr_pc_en    = wr_pc_en_q;
    assign bus.clear_board = clear_board_q;
    assign bus.pl_ack      = pl_ack_q;
    assign bus.pc_ack      = pc_ack_q;
    assign bus.pl_nack     = pl_nack_q;
    assign bus.pc_nack     = pc_nack_q;
    assign bus.turn        = turn_q;
    assign bus.move_count  = move_count_q;
    assign bus.game_over   = game_over_q;
    assign bus.result      = result_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_ttt_turn_scheduler.sv
// Scoreboard bench for ttt_turn_scheduler: stimulus queues expected pulse snapshots,
// a negedge monitor pops and compares them whenever any pulse output is active.
module tb_ttt_turn_scheduler;
    typedef struct packed {
        logic [8:0] wpl;
        logic [8:0] wpc;
        logic [5:0] pul;   // clear_board, pl_ack, pl_nack, pc_ack, pc_nack, timeout
        logic [1:0] turn;
        logic [3:0] mc;
        logic       go;
        logic [1:0] res;
    } ev_t;

    localparam logic [5:0] P_CLR = 6'b100000;
    localparam logic [5:0] P_PLA = 6'b010000;
    localparam logic [5:0] P_PLN = 6'b001000;
    localparam logic [5:0] P_PCA = 6'b000100;
    localparam logic [5:0] P_PCN = 6'b000010;
    localparam logic [5:0] P_TMO = 6'b000001;

    logic clock = 1'b0;
    logic reset = 1'b1;
    ttt_turn_scheduler_if bus();

    ttt_turn_scheduler #(.PC_FIRST(1'b0), .TIMEOUT_CYCLES(255)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    ev_t exp_q[$];
    ev_t mon_got;
    ev_t mon_want;
    int  checks = 0;
    int  errors = 0;

    function automatic ev_t snap();
        ev_t e;
        e.wpl  = bus.wr_pl_en;
        e.wpc  = bus.wr_pc_en;
        e.pul  = {bus.clear_board, bus.pl_ack, bus.pl_nack, bus.pc_ack, bus.pc_nack, bus.timeout};
        e.turn = bus.turn;
        e.mc   = bus.move_count;
        e.go   = bus.game_over;
        e.res  = bus.result;
        return e;
    endfunction

    // Monitor: every cycle with an active pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset) begin
            mon_got = snap();
            if ((mon_got.wpl != 9'd0) || (mon_got.wpc != 9'd0) || (mon_got.pul != 6'd0)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event got=%h want=none", mon_got);
                end else begin
                    mon_want = exp_q.pop_front();
                    if (mon_got !== mon_want) begin
                        errors++;
                        $display("FAIL event got=%h want=%h", mon_got, mon_want);
                    end
                end
            end
        end
    end

    task automatic expect_ev(input logic [8:0] wpl, input logic [8:0] wpc, input logic [5:0] pul,
                             input logic [1:0] turn, input logic [3:0] mc, input logic go,
                             input logic [1:0] res);
        ev_t e;
        e.wpl = wpl; e.wpc = wpc; e.pul = pul; e.turn = turn; e.mc = mc; e.go = go; e.res = res;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic lvl(input string name, input logic [1:0] turn, input logic [3:0] mc,
                       input logic go, input logic [1:0] res);
        checks++;
        if ({bus.turn, bus.move_count, bus.game_over, bus.result} !== {turn, mc, go, res}) begin
            errors++;
            $display("FAIL %s got turn=%b mc=%0d go=%b res=%b want turn=%b mc=%0d go=%b res=%b",
                     name, bus.turn, bus.move_count, bus.game_over, bus.result, turn, mc, go, res);
        end
    endtask

    task automatic chk_zero(input string name);
        checks++;
        if (snap() !== '0) begin
            errors++;
            $display("FAIL %s got=%h want=0", name, snap());
        end
    endtask

    task automatic start_game();
        expect_ev(9'h000, 9'h000, P_CLR, 2'b00, 4'd0, 1'b0, 2'b00);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.board_occ = 9'h000;
        step();
    endtask

    // Legal move: request, WRITE (board captures), CHECK (detectors sampled), decision.
    task automatic play(input logic is_pc, input logic [3:0] pos, input logic [8:0] oh,
                        input logic [3:0] mc_after, input logic win_now);
        if (is_pc) begin
            expect_ev(9'h000, oh, P_PCA, 2'b00, mc_after, 1'b0, 2'b00);
            bus.pc_req = 1'b1; bus.pc_pos = pos;
        end else begin
            expect_ev(oh, 9'h000, P_PLA, 2'b00, mc_after, 1'b0, 2'b00);
            bus.pl_req = 1'b1; bus.pl_pos = pos;
        end
        step();
        bus.pl_req = 1'b0; bus.pc_req = 1'b0;
        bus.board_occ = bus.board_occ | oh;
        step();
        bus.win = win_now;
        bus.no_space = (bus.board_occ == 9'h1FF);
        step();
        bus.win = 1'b0; bus.no_space = 1'b0;
    endtask

    task automatic pc_bad(input logic [3:0] pos, input logic [3:0] mc);
        expect_ev(9'h000, 9'h000, P_PCN, 2'b10, mc, 1'b0, 2'b00);
        bus.pc_req = 1'b1; bus.pc_pos = pos;
        step();
        bus.pc_req = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.pl_req = 1'b0; bus.pl_pos = 4'd0; bus.pc_req = 1'b0; bus.pc_pos = 4'd0;
        bus.board_occ = 9'h000; bus.win = 1'b0; bus.no_space = 1'b0;
        step(); step();
        chk_zero("reset_outputs");
        reset = 1'b0;
        step();
        chk_zero("idle_after_reset");

        // Game 1: legality, simultaneous requests, computer forfeit.
        start_game();
        lvl("g1_start", 2'b01, 4'd0, 1'b0, 2'b00);
        play(1'b0, 4'd5, 9'h010, 4'd1, 1'b0);
        lvl("g1_after_p5", 2'b10, 4'd1, 1'b0, 2'b00);
        pc_bad(4'd5, 4'd1);
        pc_bad(4'd0, 4'd1);
        pc_bad(4'd12, 4'd1);
        lvl("g1_after_nacks", 2'b10, 4'd1, 1'b0, 2'b00);
        play(1'b1, 4'd1, 9'h001, 4'd2, 1'b0);
        lvl("g1_after_c1", 2'b01, 4'd2, 1'b0, 2'b00);
        expect_ev(9'h002, 9'h000, P_PLA | P_PCN, 2'b00, 4'd3, 1'b0, 2'b00);
        bus.pl_req = 1'b1; bus.pl_pos = 4'd2; bus.pc_req = 1'b1; bus.pc_pos = 4'd3;
        step();
        bus.pl_req = 1'b0; bus.pc_req = 1'b0;
        bus.board_occ = bus.board_occ | 9'h002;
        step(); step();
        lvl("g1_after_simul", 2'b10, 4'd3, 1'b0, 2'b00);
        for (int i = 0; i < 254; i++) step();
        lvl("g1_before_timeout", 2'b10, 4'd3, 1'b0, 2'b00);
        expect_ev(9'h000, 9'h000, P_TMO, 2'b00, 4'd3, 1'b1, 2'b01);
        step();
        lvl("g1_timeout", 2'b00, 4'd3, 1'b1, 2'b01);
        bus.pl_req = 1'b1; bus.pl_pos = 4'd7; bus.pc_req = 1'b1; bus.pc_pos = 4'd8;
        step(); step();
        bus.pl_req = 1'b0; bus.pc_req = 1'b0;
        lvl("g1_done_ignores", 2'b00, 4'd3, 1'b1, 2'b01);

        // Game 2: player waits indefinitely, mid-game start ignored, player wins.
        start_game();
        for (int i = 0; i < 300; i++) begin
            bus.start = (i == 100);
            step();
        end
        bus.start = 1'b0;
        lvl("g2_player_waits", 2'b01, 4'd0, 1'b0, 2'b00);
        play(1'b0, 4'd1, 9'h001, 4'd1, 1'b0);
        lvl("g2_m1", 2'b10, 4'd1, 1'b0, 2'b00);
        play(1'b1, 4'd4, 9'h008, 4'd2, 1'b0);
        lvl("g2_m2", 2'b01, 4'd2, 1'b0, 2'b00);
        play(1'b0, 4'd2, 9'h002, 4'd3, 1'b0);
        play(1'b1, 4'd5, 9'h010, 4'd4, 1'b0);
        play(1'b0, 4'd3, 9'h004, 4'd5, 1'b1);
        lvl("g2_player_win", 2'b00, 4'd5, 1'b1, 2'b01);
        bus.pc_req = 1'b1; bus.pc_pos = 4'd9;
        step(); step();
        bus.pc_req = 1'b0;
        lvl("g2_done_hold", 2'b00, 4'd5, 1'b1, 2'b01);

        // Game 3: nine moves, draw.
        start_game();
        for (int i = 0; i < 9; i++) begin
            play(i[0], 4'(i + 1), 9'h001 << i, 4'(i + 1), 1'b0);
            if (i < 8) lvl("g3_turn", i[0] ? 2'b01 : 2'b10, 4'(i + 1), 1'b0, 2'b00);
        end
        lvl("g3_draw", 2'b00, 4'd9, 1'b1, 2'b11);

        // Game 4: computer wins.
        start_game();
        play(1'b0, 4'd1, 9'h001, 4'd1, 1'b0);
        play(1'b1, 4'd5, 9'h010, 4'd2, 1'b1);
        lvl("g4_pc_win", 2'b00, 4'd2, 1'b1, 2'b10);

        // Game 5: reset lands in WRITE while the write enable is live.
        start_game();
        expect_ev(9'h010, 9'h000, P_PLA, 2'b00, 4'd1, 1'b0, 2'b00);
        bus.pl_req = 1'b1; bus.pl_pos = 4'd5;
        step();
        bus.pl_req = 1'b0;
        #5;
        reset = 1'b1;
        #1;
        chk_zero("reset_in_write");
        step(); step();
        reset = 1'b0;
        bus.pl_req = 1'b1; bus.pl_pos = 4'd2;
        step(); step();
        bus.pl_req = 1'b0;
        chk_zero("idle_after_midgame_reset");
        start_game();
        lvl("restart_after_reset", 2'b01, 4'd0, 1'b0, 2'b00);

        step(); step(); step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ttt_turn_scheduler.md
Name: ttt_turn_scheduler

Overview:
Sequences a tic-tac-toe game over the nine-cell board datapath (position registers, winner detector, no-space detector). It accepts move requests from the player and computer ports and enforces strict turn alternation. It checks each move against board occupancy, then issues one-cycle one-hot write enables to the position registers. It waits for the detectors to settle, then either declares a result or passes the turn to the other side, with a computer-move timeout that forfeits the game.

Parameters:
PC_FIRST, 0, 1 = computer moves first after start, 0 = player moves first
TIMEOUT_CYCLES, 255, cycles the computer may hold its turn without a legal move before forfeit (1..255)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; all state and outputs to reset values
start  in  1  begin a new game (honoured only in IDLE or DONE)
pl_req  in  1  player move request, sampled at rising edge
pl_pos  in  4  player cell, 1..9 valid
pc_req  in  1  computer move request
pc_pos  in  4  computer cell, 1..9 valid
board_occ  in  9  bit i = cell i+1 occupied (either code nonzero)
win  in  1  winner detector output
no_space  in  1  no-space detector output
wr_pl_en  out  9  one-hot player write enable, one-cycle pulse
wr_pc_en  out  9  one-hot computer write enable, one-cycle pulse
clear_board  out  1  one-cycle pulse requesting board clear
pl_ack, pc_ack  out  1 each  one-cycle pulse: move accepted
pl_nack, pc_nack  out  1 each  one-cycle pulse: move rejected
turn  out  2  01 player to move, 10 computer to move, 00 neither
move_count  out  4  accepted moves this game, 0..9
game_over  out  1  level, high in DONE
result  out  2  00 none, 01 player won, 10 computer won, 11 draw
timeout  out  1  one-cycle pulse on computer forfeit

Behaviour:
- Reset values: all outputs 0, state IDLE, move_count 0, result 00, internal last_mover 0, timeout counter 0.
- All outputs are registered: a decision at edge N is visible in cycle N..N+1.
- States: IDLE, CLEAR, PL_TURN, PC_TURN, WRITE, CHECK, DONE.
- IDLE/DONE with start=1: go to CLEAR, pulse clear_board, zero move_count, result and game_over.
- CLEAR: always exits next edge, to PC_TURN if PC_FIRST=1, otherwise to PL_TURN.
- turn is 01 in PL_TURN and 10 in PC_TURN; 00 in every other state.
- Legal move: the request comes from the side holding the turn, pos is in 1..9, and board_occ[pos-1]=0.
- Legal move: the next cycle asserts the matching wr_*_en (bit pos-1) and *_ack. move_count increments, last_mover is recorded, and the state goes to WRITE.
- Illegal pos (0, 10..15, or occupied cell): the matching *_nack pulses next cycle, the state stays unchanged, and no write occurs.
- Out-of-turn request: *_nack pulses whenever the state is PL_TURN or PC_TURN.
- Requests in IDLE, CLEAR, WRITE, CHECK or DONE are ignored silently, with no ack and no nack.
- Simultaneous pl_req and pc_req: only the turn holder's request is evaluated; the other side receives nack.
- WRITE: lasts one cycle, the cycle in which the position registers capture. It always goes to CHECK.
- CHECK: the board now reflects the move, and win/no_space are sampled.
  - win=1: result = last_mover code (01 or 10), go to DONE.
  - Otherwise, no_space=1 or move_count=9: result = 11, go to DONE.
  - Otherwise: go to the opposite side's turn.
- Timeout: the counter clears on entry to PC_TURN and increments each PC_TURN cycle without a legal pc move. At TIMEOUT_CYCLES it pulses timeout, sets result=01, and goes to DONE. It is not active in PL_TURN (human may wait indefinitely).
- DONE: game_over=1 and result is held until start or reset. start in any other state is ignored.
- Asynchronous reset mid-game (including during WRITE) forces IDLE immediately; no write enable survives the reset.

Test Plan:
- Reset, start (PC_FIRST=0) -> clear_board pulse; then turn=01; move_count=0; result=00.
- Player pos 5 (board_occ=0) -> next cycle wr_pl_en=9'h010 and pl_ack; then CHECK; then turn=10; move_count=1.
- Computer pos 5 with board_occ[4]=1, then pos 0, then pos 12 -> three pc_nack pulses, no wr_pc_en, turn stays 10.
- Player sequence 1,2,3 against computer 4,5, with win=1 after the third player move -> result=01, game_over=1; later requests ignored.
- Nine alternating legal moves with win=0 -> result=11 after the ninth CHECK; move_count=9.
- Computer idle for 255 cycles in PC_TURN -> timeout pulse, result=01, game_over=1.
- pl_req and pc_req together during PL_TURN -> pl_ack plus pc_nack.
- Reset asserted during WRITE -> all outputs 0 and state IDLE at once.
